// File: rtl/fifo_conv.sv
// fifo_conv: width-converting show-ahead FIFO. Each accepted input word is
// split into RATIO output slices that are stored back to back; the consumer
// sees the head slice combinationally and pops one slice per cycle.
module fifo_conv #(
   parameter int OUT_W     = 8,
   parameter int RATIO     = 2,
   parameter int DEPTH     = 16,
   parameter int MSB_FIRST = 1,
   parameter int AFULL_TH  = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       input_valid,
   output logic                       input_enable,
   input  logic [OUT_W*RATIO-1:0]     data_in,
   output logic                       output_valid,
   input  logic                       output_enable,
   output logic [OUT_W-1:0]           data_out,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] RATIO_L = LW'(RATIO);
   // When RATIO == DEPTH this truncates to 0, which is the correct modulo step.
   localparam logic [AW-1:0] RATIO_P = AW'(RATIO);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_write;
   logic             do_read;

   // Position of the input slice that lands at write offset i.
   function automatic int slice_sel(input int i);
      return (MSB_FIRST != 0) ? (RATIO - 1 - i) : i;
   endfunction

   // Space is judged on the current level only, so a same-cycle pop never
   // opens room for a write.
   assign input_enable = (DEPTH_L - level) >= RATIO_L;
   assign output_valid = (level != '0);
   assign almost_full  = (32'(level) >= AFULL_TH);
   assign data_out     = output_valid ? mem[rd_ptr] : '0;

   assign do_write = input_valid && input_enable && !flush;
   assign do_read  = output_valid && output_enable && !flush;

   // Pointer and level bookkeeping; rst outranks flush, flush outranks traffic.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so level and pointers update consistently.
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + RATIO_P;
         if (do_read)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + (do_write ? RATIO_L : '0) - (do_read ? LW'(1) : '0);
      end
   end

   // Slice storage: RATIO consecutive entries per accepted input word.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; stale contents are unreachable because
      // level gates output_valid and data_out.
      if (!rst && do_write) begin
         for (int i = 0; i < RATIO; i++) begin
            mem[wr_ptr + AW'(i)] <= data_in[slice_sel(i)*OUT_W +: OUT_W];
         end
      end
   end

endmodule

// File: tb/tb_fifo_conv.sv
// tb_fifo_conv: table-driven check of fifo_conv with default parameters, plus
// a hand-written sequence on a second instance emitting LSB slice first.
module tb_fifo_conv;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance (MSB first)
   logic        rst = 1'b1, flush = 1'b0, input_valid = 1'b0, output_enable = 1'b0;
   logic [15:0] data_in = '0;
   logic        input_enable, output_valid, almost_full;
   logic [7:0]  data_out;
   logic [4:0]  level;

   fifo_conv dut (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(input_valid), .input_enable(input_enable), .data_in(data_in),
      .output_valid(output_valid), .output_enable(output_enable), .data_out(data_out),
      .level(level), .almost_full(almost_full)
   );

   // LSB-first instance
   logic        l_rst = 1'b1, l_flush = 1'b0, l_iv = 1'b0, l_oe = 1'b0;
   logic [15:0] l_din = '0;
   logic        l_ie, l_ov, l_af;
   logic [7:0]  l_dout;
   logic [4:0]  l_level;

   fifo_conv #(.MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(l_rst), .flush(l_flush),
      .input_valid(l_iv), .input_enable(l_ie), .data_in(l_din),
      .output_valid(l_ov), .output_enable(l_oe), .data_out(l_dout),
      .level(l_level), .almost_full(l_af)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst;
      logic        flush;
      logic        iv;
      logic [15:0] din;
      logic        oe;
      logic        ev;
      logic [7:0]  ed;
      int          el;
      logic        eie;
      logic        eaf;
   } vec_t;

   vec_t vecs[$];

   // Expected flags follow from the expected level: 16-entry store, 2 slices
   // per write, almost_full threshold 12.
   task automatic add(input string name, input logic r, input logic f, input logic iv,
                      input logic [15:0] din, input logic oe, input logic [7:0] ed, input int el);
      vec_t v;
      v.name = name; v.rst = r; v.flush = f; v.iv = iv; v.din = din; v.oe = oe;
      v.ed = ed; v.el = el;
      v.ev  = (el != 0);
      v.eie = ((16 - el) >= 2);
      v.eaf = (el >= 12);
      vecs.push_back(v);
   endtask

   initial begin
      // Reset and the basic A5C3 transaction
      add("reset",      1, 0, 0, 16'h0000, 0, 8'h00, 0);
      add("wr_a5c3",    0, 0, 1, 16'hA5C3, 0, 8'hA5, 2);
      add("pop1",       0, 0, 0, 16'h0000, 1, 8'hC3, 1);
      add("pop2",       0, 0, 0, 16'h0000, 1, 8'h00, 0);
      add("pop_empty",  0, 0, 0, 16'h0000, 1, 8'h00, 0);
      // Fill to full from pointer 2 so the data wraps
      for (int n = 1; n <= 8; n++)
         add($sformatf("fill%0d", n), 0, 0, 1, {8'(2*n-1), 8'(2*n)}, 0, 8'h01, 2*n);
      add("wr_full",    0, 0, 1, 16'hFFFF, 0, 8'h01, 16);
      for (int k = 1; k <= 16; k++)
         add($sformatf("drain%0d", k), 0, 0, 0, 16'h0000, 1, (k < 16) ? 8'(k+1) : 8'h00, 16-k);
      // Simultaneous write and read at level 4
      add("wr_0a0b",    0, 0, 1, 16'h0A0B, 0, 8'h0A, 2);
      add("wr_0c0d",    0, 0, 1, 16'h0C0D, 0, 8'h0A, 4);
      add("wr_rd_l4",   0, 0, 1, 16'h0E0F, 1, 8'h0B, 5);
      add("pop_l5",     0, 0, 0, 16'h0000, 1, 8'h0C, 4);
      add("wr_1112",    0, 0, 1, 16'h1112, 0, 8'h0C, 6);
      add("wr_1314",    0, 0, 1, 16'h1314, 0, 8'h0C, 8);
      add("wr_1516",    0, 0, 1, 16'h1516, 0, 8'h0C, 10);
      // Flush beats simultaneous write and read
      add("flush_l10",  0, 1, 1, 16'h7777, 1, 8'h00, 0);
      add("after_flush",0, 0, 0, 16'h0000, 0, 8'h00, 0);
      // Reset mid-operation at level 6
      add("wr_2122",    0, 0, 1, 16'h2122, 0, 8'h21, 2);
      add("wr_2324",    0, 0, 1, 16'h2324, 0, 8'h21, 4);
      add("wr_2526",    0, 0, 1, 16'h2526, 0, 8'h21, 6);
      add("rst_l6",     1, 0, 1, 16'h9999, 1, 8'h00, 0);
      add("first_wr",   0, 0, 1, 16'h4142, 0, 8'h41, 2);
      add("rst_flush",  1, 1, 1, 16'h5555, 1, 8'h00, 0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; flush = vecs[i].flush; input_valid = vecs[i].iv;
         data_in = vecs[i].din; output_enable = vecs[i].oe;
         @(posedge clk); #1;
         check({vecs[i].name, ".output_valid"}, 32'(output_valid), 32'(vecs[i].ev));
         check({vecs[i].name, ".data_out"},     32'(data_out),     32'(vecs[i].ed));
         check({vecs[i].name, ".level"},        32'(level),        32'(vecs[i].el));
         check({vecs[i].name, ".input_enable"}, 32'(input_enable), 32'(vecs[i].eie));
         check({vecs[i].name, ".almost_full"},  32'(almost_full),  32'(vecs[i].eaf));
      end
      rst = 1'b0; input_valid = 1'b0; output_enable = 1'b0; flush = 1'b0;

      // LSB-first ordering on the second instance
      l_rst = 1'b0; l_iv = 1'b1; l_din = 16'hA5C3;
      @(posedge clk); #1;
      l_iv = 1'b0;
      check("lsb.valid0", 32'(l_ov),    32'd1);
      check("lsb.data0",  32'(l_dout),  32'hC3);
      check("lsb.level0", 32'(l_level), 32'd2);
      l_oe = 1'b1;
      @(posedge clk); #1;
      check("lsb.data1",  32'(l_dout),  32'hA5);
      check("lsb.level1", 32'(l_level), 32'd1);
      @(posedge clk); #1;
      l_oe = 1'b0;
      check("lsb.valid2", 32'(l_ov),    32'd0);
      check("lsb.data2",  32'(l_dout),  32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
